// File: rtl/regfile_write_arbiter.sv
// Four-requester round-robin write arbiter for a single register-file write port.
// Define REGFILE_CLEAR_EN to add a post-reset sweep that zeroes every register before arbitration.
module regfile_write_arbiter #(
    parameter int unsigned DBITS = 32,
    parameter int unsigned ABITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req_valid,
    input  logic [4*ABITS-1:0] req_ind,
    input  logic [4*DBITS-1:0] req_data,
    output logic [3:0]         req_ready,
    output logic               rf_wrtEn,
    output logic [ABITS-1:0]   rf_wrtInd,
    output logic [DBITS-1:0]   rf_dIn,
    output logic               busy,
    output logic [1:0]         grant_id
);

    logic [1:0] last_grant;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;
    logic       arb_en;
    logic       xfer;

`ifdef REGFILE_CLEAR_EN
    typedef enum logic {StClear, StArb} state_e;
    state_e           state;
    logic [ABITS-1:0] sweep_cnt;

    assign arb_en = (state == StArb);
`else
    assign arb_en = 1'b1;
    assign busy   = 1'b0;
`endif

    // Search starts one past the last granted requester and wraps 3 -> 0.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!found && req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        req_ready = '0;
        if (arb_en && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign xfer = arb_en && found;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_wrtEn   <= 1'b0;
            rf_wrtInd  <= '0;
            rf_dIn     <= '0;
            grant_id   <= '0;
            last_grant <= 2'd3;
`ifdef REGFILE_CLEAR_EN
            state      <= StClear;
            busy       <= 1'b1;
            sweep_cnt  <= '0;
`endif
        end else begin
            rf_wrtEn <= xfer;
            if (xfer) begin
                rf_wrtInd  <= req_ind[winner*ABITS +: ABITS];
                rf_dIn     <= req_data[winner*DBITS +: DBITS];
                grant_id   <= winner;
                last_grant <= winner;
            end
`ifdef REGFILE_CLEAR_EN
            if (state == StClear) begin
                rf_wrtEn  <= 1'b1;
                rf_wrtInd <= sweep_cnt;
                rf_dIn    <= '0;
                sweep_cnt <= sweep_cnt + 1'b1;
                // Leave the sweep on the edge that issues the last index.
                if (&sweep_cnt) begin
                    state <= StArb;
                    busy  <= 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (DBITS=32, ABITS=4); sweep scenarios
// are included only when REGFILE_CLEAR_EN is defined.
module tb_regfile_write_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [15:0]  req_ind;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         rf_wrtEn;
    logic [3:0]   rf_wrtInd;
    logic [31:0]  rf_dIn;
    logic         busy;
    logic [1:0]   grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_arbiter #(.DBITS(32), .ABITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ind   (req_ind),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_wrtEn  (rf_wrtEn),
        .rf_wrtInd (rf_wrtInd),
        .rf_dIn    (rf_dIn),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REGFILE_CLEAR_EN
    localparam logic BUSY_AT_RESET = 1'b1;
`else
    localparam logic BUSY_AT_RESET = 1'b0;
`endif

    // Ends on a falling edge with the DUT ready to arbitrate.
    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_ind   = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
`ifdef REGFILE_CLEAR_EN
        repeat (16) @(posedge clk);
        @(negedge clk);
`endif
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_ind   = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (rf_wrtEn !== 1'b0) begin n_fail++;
            $display("FAIL reset_wrtEn: got %b expected 0", rf_wrtEn); end
        n_checks++; if (rf_wrtInd !== 4'd0) begin n_fail++;
            $display("FAIL reset_wrtInd: got %h expected 0", rf_wrtInd); end
        n_checks++; if (rf_dIn !== 32'd0) begin n_fail++;
            $display("FAIL reset_dIn: got %h expected 0", rf_dIn); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++;
            $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        n_checks++; if (busy !== BUSY_AT_RESET) begin n_fail++;
            $display("FAIL reset_busy: got %b expected %b", busy, BUSY_AT_RESET); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++;
            $display("FAIL reset_ready_idle: got %b expected 0000", req_ready); end
    endtask

    task automatic test_single();
        do_reset();
        req_valid         = 4'b0100;
        req_ind[11:8]     = 4'd5;
        req_data[95:64]   = 32'hDEADBEEF;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++;
            $display("FAIL single_ready: got %b expected 0100", req_ready); end
        @(posedge clk); #1;
        n_checks++; if (rf_wrtEn !== 1'b1) begin n_fail++;
            $display("FAIL single_wrtEn: got %b expected 1", rf_wrtEn); end
        n_checks++; if (rf_wrtInd !== 4'd5) begin n_fail++;
            $display("FAIL single_wrtInd: got %h expected 5", rf_wrtInd); end
        n_checks++; if (rf_dIn !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL single_dIn: got %h expected deadbeef", rf_dIn); end
        n_checks++; if (grant_id !== 2'd2) begin n_fail++;
            $display("FAIL single_grant_id: got %0d expected 2", grant_id); end
        @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk); #1;
        n_checks++; if (rf_wrtEn !== 1'b0) begin n_fail++;
            $display("FAIL idle_wrtEn: got %b expected 0", rf_wrtEn); end
        n_checks++; if (rf_wrtInd !== 4'd5 || rf_dIn !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL idle_hold: got %h/%h expected 5/deadbeef", rf_wrtInd, rf_dIn); end
        n_checks++; if (grant_id !== 2'd2) begin n_fail++;
            $display("FAIL idle_grant_hold: got %0d expected 2", grant_id); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_ready;
        logic [1:0] exp_id;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_ind[i*4 +: 4]   = 4'(i + 1);
            req_data[i*32 +: 32] = 32'h100 + 32'(i);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            exp_id    = 2'(c % 4);
            exp_ready = 4'b0001 << exp_id;
            #1;
            n_checks++; if (req_ready !== exp_ready) begin n_fail++;
                $display("FAIL fair_ready[%0d]: got %b expected %b", c, req_ready, exp_ready); end
            @(posedge clk); #1;
            n_checks++; if (rf_wrtEn !== 1'b1 || grant_id !== exp_id) begin n_fail++;
                $display("FAIL fair_grant[%0d]: got en=%b id=%0d expected en=1 id=%0d",
                         c, rf_wrtEn, grant_id, exp_id); end
            n_checks++; if (rf_wrtInd !== 4'(exp_id + 1) || rf_dIn !== 32'h100 + 32'(exp_id))
                begin n_fail++;
                $display("FAIL fair_data[%0d]: got %h/%h expected %h/%h", c, rf_wrtInd,
                         rf_dIn, 4'(exp_id + 1), 32'h100 + 32'(exp_id)); end
            @(negedge clk);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_skip_idle();
        do_reset();
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++;
            $display("FAIL skip_ready_a: got %b expected 1000", req_ready); end
        @(posedge clk); #1;
        n_checks++; if (rf_wrtEn !== 1'b1 || grant_id !== 2'd3) begin n_fail++;
            $display("FAIL skip_grant_a: got en=%b id=%0d expected en=1 id=3", rf_wrtEn, grant_id); end
        @(negedge clk); #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++;
            $display("FAIL skip_ready_b: got %b expected 0001", req_ready); end
        @(posedge clk); #1;
        n_checks++; if (rf_wrtEn !== 1'b1 || grant_id !== 2'd0) begin n_fail++;
            $display("FAIL skip_grant_b: got en=%b id=%0d expected en=1 id=0", rf_wrtEn, grant_id); end
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    task automatic test_same_index();
        do_reset();
        req_ind[3:0]    = 4'd7;
        req_ind[7:4]    = 4'd7;
        req_data[31:0]  = 32'h11;
        req_data[63:32] = 32'h22;
        req_valid       = 4'b0011;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++;
            $display("FAIL same_ready_a: got %b expected 0001", req_ready); end
        @(posedge clk); #1;
        n_checks++; if (rf_wrtEn !== 1'b1 || rf_wrtInd !== 4'd7 || rf_dIn !== 32'h11) begin
            n_fail++;
            $display("FAIL same_write_a: got en=%b ind=%h d=%h expected en=1 ind=7 d=11",
                     rf_wrtEn, rf_wrtInd, rf_dIn); end
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++;
            $display("FAIL same_ready_b: got %b expected 0010", req_ready); end
        @(posedge clk); #1;
        n_checks++; if (rf_wrtEn !== 1'b1 || rf_wrtInd !== 4'd7 || rf_dIn !== 32'h22) begin
            n_fail++;
            $display("FAIL same_write_b: got en=%b ind=%h d=%h expected en=1 ind=7 d=22",
                     rf_wrtEn, rf_wrtInd, rf_dIn); end
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    task automatic test_drop_valid();
        do_reset();
        req_valid = 4'b0011;
        @(posedge clk); #1;
        n_checks++; if (grant_id !== 2'd0 || rf_wrtEn !== 1'b1) begin n_fail++;
            $display("FAIL drop_first: got en=%b id=%0d expected en=1 id=0", rf_wrtEn, grant_id); end
        @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk); #1;
        n_checks++; if (rf_wrtEn !== 1'b0) begin n_fail++;
            $display("FAIL drop_no_write: got %b expected 0", rf_wrtEn); end
        @(negedge clk);
        req_valid = 4'b1010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++;
            $display("FAIL drop_last_grant: got %b expected 0010", req_ready); end
        @(posedge clk); #1;
        n_checks++; if (grant_id !== 2'd1) begin n_fail++;
            $display("FAIL drop_grant: got %0d expected 1", grant_id); end
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        req_data  = {4{32'hA5A5_0001}};
        req_ind   = 16'hFFFF;
        req_valid = 4'b1111;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_checks++; if (rf_wrtEn !== 1'b0 || rf_wrtInd !== 4'd0 || rf_dIn !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got en=%b ind=%h d=%h expected all 0",
                     rf_wrtEn, rf_wrtInd, rf_dIn); end
        n_checks++; if (grant_id !== 2'd0 || busy !== BUSY_AT_RESET) begin n_fail++;
            $display("FAIL rst_mid_state: got id=%0d busy=%b expected 0/%b",
                     grant_id, busy, BUSY_AT_RESET); end
        @(negedge clk);
        reset = 1'b0;
`ifndef REGFILE_CLEAR_EN
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++;
            $display("FAIL rst_mid_restart: got %b expected 0001", req_ready); end
        @(posedge clk); #1;
        n_checks++; if (grant_id !== 2'd0 || rf_wrtEn !== 1'b1) begin n_fail++;
            $display("FAIL rst_mid_first: got en=%b id=%0d expected en=1 id=0", rf_wrtEn, grant_id); end
`endif
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

`ifdef REGFILE_CLEAR_EN
    task automatic test_clear();
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (busy !== 1'b1) begin n_fail++;
                $display("FAIL clear_busy[%0d]: got %b expected 1", k, busy); end
            @(posedge clk); #1;
            n_checks++; if (rf_wrtEn !== 1'b1 || rf_wrtInd !== 4'(k) || rf_dIn !== 32'd0) begin
                n_fail++;
                $display("FAIL clear_write[%0d]: got en=%b ind=%h d=%h expected en=1 ind=%h d=0",
                         k, rf_wrtEn, rf_wrtInd, rf_dIn, 4'(k)); end
            @(negedge clk);
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL clear_busy_end: got %b expected 0", busy); end
        @(posedge clk); #1;
        n_checks++; if (rf_wrtEn !== 1'b0) begin n_fail++;
            $display("FAIL clear_after: got %b expected 0", rf_wrtEn); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep();
        reset     = 1'b1;
        req_valid = 4'b0001;
        req_ind   = 16'h0003;
        req_data  = 128'h77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (rf_wrtInd !== 4'd9 || req_ready !== 4'b0000) begin n_fail++;
            $display("FAIL sweep_at9: got ind=%h ready=%b expected 9/0000", rf_wrtInd, req_ready); end
        reset = 1'b1;
        #1;
        n_checks++; if (rf_wrtEn !== 1'b0 || rf_wrtInd !== 4'd0 || busy !== 1'b1) begin n_fail++;
            $display("FAIL sweep_rst: got en=%b ind=%h busy=%b expected 0/0/1",
                     rf_wrtEn, rf_wrtInd, busy); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (rf_wrtEn !== 1'b1 || rf_wrtInd !== 4'd0) begin n_fail++;
            $display("FAIL sweep_restart: got en=%b ind=%h expected 1/0", rf_wrtEn, rf_wrtInd); end
        repeat (15) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (req_ready !== 4'b0001 || busy !== 1'b0) begin n_fail++;
            $display("FAIL sweep_held_req: got ready=%b busy=%b expected 0001/0", req_ready, busy); end
        @(posedge clk); #1;
        n_checks++; if (rf_wrtEn !== 1'b1 || rf_wrtInd !== 4'd3 || rf_dIn !== 32'h77) begin
            n_fail++;
            $display("FAIL sweep_served: got en=%b ind=%h d=%h expected 1/3/77",
                     rf_wrtEn, rf_wrtInd, rf_dIn); end
        @(negedge clk);
        req_valid = 4'b0000;
    endtask
`endif

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_ind   = '0;
        req_data  = '0;
        test_reset();
        test_single();
        test_fairness();
        test_skip_idle();
        test_same_index();
        test_drop_valid();
        test_reset_mid_transfer();
`ifdef REGFILE_CLEAR_EN
        test_clear();
        test_reset_mid_sweep();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
